// File: rtl/trsq8_io_pkg.sv
// Shared definitions for TRSQ8 memory-mapped IO blocks: register offsets,
// control/status bit positions and the default IO window base.
package trsq8_io_pkg;

   localparam int unsigned IO_DATA_W = 8;
   localparam int unsigned IO_ADDR_W = 8;
   localparam logic [7:0]  IO_BASE_ADDR = 8'hF0;

   typedef enum logic [2:0] {
      REG_CTRL   = 3'd0,
      REG_PRESC  = 3'd1,
      REG_CMP    = 3'd2,
      REG_COUNT  = 3'd3,
      REG_STATUS = 3'd4
   } reg_off_e;

   localparam int unsigned CTRL_EN    = 0;
   localparam int unsigned CTRL_IE    = 1;
   localparam int unsigned CTRL_CLR   = 2;
   localparam int unsigned STAT_MATCH = 0;
   localparam int unsigned STAT_OVF   = 1;

endpackage

// File: rtl/io_prescaler.sv
// Clock prescaler: emits a one-cycle tick every presc+1 cycles while enabled.
module io_prescaler
   import trsq8_io_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en,
   input  logic                 clr,
   input  logic [IO_DATA_W-1:0] presc,
   output logic                 tick
);

   logic [IO_DATA_W-1:0] psc;

   // >= rather than == so that lowering presc below psc ticks immediately
   always_comb begin
      tick = en && (psc >= presc);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         psc <= '0;
      end else if (!en || clr || tick) begin
         psc <= '0;
      end else begin
         psc <= psc + IO_DATA_W'(1);
      end
   end

endmodule

// File: rtl/io_timer.sv
// Memory-mapped timer on the TRSQ8 data bus: register window, prescaled
// counter with compare-match/overflow flags and a level interrupt.
module io_timer
   import trsq8_io_pkg::*;
#(
   parameter logic [7:0]  BASE_ADDR = IO_BASE_ADDR,
   parameter int unsigned DATA_W    = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              we,
   input  logic              re,
   output logic [DATA_W-1:0] rdata,
   output logic              irq
);

   logic [2:0]        ctrl;
   logic [DATA_W-1:0] presc;
   logic [DATA_W-1:0] cmp;
   logic [DATA_W-1:0] count;
   logic              match;
   logic              ovf;

   logic              hit_c;
   logic [2:0]        off_c;
   logic              wr_ctrl_c, wr_presc_c, wr_cmp_c, wr_count_c, wr_status_c;
   logic              tick;
   logic [DATA_W-1:0] nxt_c;
   logic              set_match_c;
   logic              set_ovf_c;
   logic [DATA_W-1:0] rd_val_c;

   io_prescaler u_presc (
      .clk   (clk),
      .reset (reset),
      .en    (ctrl[CTRL_EN]),
      .clr   (wr_count_c),
      .presc (presc),
      .tick  (tick)
   );

   // Address decode and per-register write strobes
   always_comb begin
      hit_c       = (addr[7:3] == BASE_ADDR[7:3]);
      off_c       = addr[2:0];
      wr_ctrl_c   = we && hit_c && (off_c == REG_CTRL);
      wr_presc_c  = we && hit_c && (off_c == REG_PRESC);
      wr_cmp_c    = we && hit_c && (off_c == REG_CMP);
      wr_count_c  = we && hit_c && (off_c == REG_COUNT);
      wr_status_c = we && hit_c && (off_c == REG_STATUS);
   end

   // A CPU write to COUNT pre-empts the tick, so it cannot raise a flag
   always_comb begin
      nxt_c       = count + DATA_W'(1);
      set_match_c = tick && !wr_count_c && (nxt_c == cmp);
      set_ovf_c   = tick && !wr_count_c && (count == {DATA_W{1'b1}});
   end

   always_comb begin
      rd_val_c = '0;
      case (off_c)
         REG_CTRL:   rd_val_c = DATA_W'(ctrl);
         REG_PRESC:  rd_val_c = presc;
         REG_CMP:    rd_val_c = cmp;
         REG_COUNT:  rd_val_c = count;
         REG_STATUS: rd_val_c = DATA_W'({ovf, match});
         default:    rd_val_c = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl  <= '0;
         presc <= '0;
         cmp   <= '0;
         count <= '0;
         match <= 1'b0;
         ovf   <= 1'b0;
         rdata <= '0;
         irq   <= 1'b0;
      end else begin
         if (wr_ctrl_c)  ctrl  <= wdata[2:0];
         if (wr_presc_c) presc <= wdata;
         if (wr_cmp_c)   cmp   <= wdata;

         if (wr_count_c) begin
            count <= wdata;
         end else if (tick) begin
            count <= (set_match_c && ctrl[CTRL_CLR]) ? '0 : nxt_c;
         end

         // Hardware set has priority over write-1-to-clear
         match <= set_match_c || (match && !(wr_status_c && wdata[STAT_MATCH]));
         ovf   <= set_ovf_c   || (ovf   && !(wr_status_c && wdata[STAT_OVF]));

         rdata <= (re && hit_c) ? rd_val_c : '0;
         irq   <= ctrl[CTRL_IE] && (match || ovf);
      end
   end

endmodule

// File: tb/tb_io_timer.sv
// Directed self-checking bench for io_timer.
module tb_io_timer;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] addr;
   logic [7:0] wdata;
   logic       we;
   logic       re;
   logic [7:0] rdata;
   logic       irq;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [7:0] A_CTRL   = 8'hF0;
   localparam logic [7:0] A_PRESC  = 8'hF1;
   localparam logic [7:0] A_CMP    = 8'hF2;
   localparam logic [7:0] A_COUNT  = 8'hF3;
   localparam logic [7:0] A_STATUS = 8'hF4;

   io_timer dut (
      .clk   (clk),
      .reset (reset),
      .addr  (addr),
      .wdata (wdata),
      .we    (we),
      .re    (re),
      .rdata (rdata),
      .irq   (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      addr = a; wdata = d; we = 1'b1;
      @(posedge clk);
      #1 we = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, output logic [7:0] q);
      @(negedge clk);
      addr = a; re = 1'b1;
      @(posedge clk);
      #1 re = 1'b0;
      q = rdata;
   endtask

   task automatic rdwr(input logic [7:0] a, input logic [7:0] d, output logic [7:0] q);
      @(negedge clk);
      addr = a; wdata = d; we = 1'b1; re = 1'b1;
      @(posedge clk);
      #1 we = 1'b0; re = 1'b0;
      q = rdata;
   endtask

   initial begin
      logic [7:0] q;
      logic [7:0] exp_seq [4];
      exp_seq[0] = 8'h01; exp_seq[1] = 8'h00; exp_seq[2] = 8'h01; exp_seq[3] = 8'h00;

      reset = 1'b1; addr = '0; wdata = '0; we = 1'b0; re = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_rdata", rdata, 8'h00);
      check("rst_irq", {7'd0, irq}, 8'h00);
      @(negedge clk) reset = 1'b0;

      // 1: reset values across the window, and an out-of-window read
      for (int i = 0; i < 8; i++) begin
         rd(8'hF0 + 8'(i), q);
         check($sformatf("rst_reg%0d", i), q, 8'h00);
      end
      rd(8'hE0, q);
      check("miss_E0", q, 8'h00);
      check("rst_irq2", {7'd0, irq}, 8'h00);

      // 2: PRESC=3 CMP=5 -> 5th tick at 20 edges after EN write, irq one later
      wr(A_PRESC, 8'd3);
      wr(A_CMP, 8'd5);
      wr(A_CTRL, 8'b011);
      repeat (19) @(posedge clk);
      #1 check("t2_irq_e19", {7'd0, irq}, 8'h00);
      @(posedge clk);
      #1 check("t2_irq_e20", {7'd0, irq}, 8'h00);
      @(posedge clk);
      #1 check("t2_irq_e21", {7'd0, irq}, 8'h01);
      rd(A_STATUS, q);
      check("t2_status", q, 8'h01);
      wr(A_STATUS, 8'h01);
      check("t2_irq_hold", {7'd0, irq}, 8'h01);
      @(posedge clk);
      #1 check("t2_irq_clr", {7'd0, irq}, 8'h00);
      wr(A_CTRL, 8'h00);
      rd(A_COUNT, q);
      check("t2_count", q, 8'h06);

      // 3: clear-on-match with CMP=2 -> COUNT alternates 1,0
      wr(A_COUNT, 8'h00);
      wr(A_STATUS, 8'h03);
      wr(A_PRESC, 8'h00);
      wr(A_CMP, 8'h02);
      wr(A_CTRL, 8'b111);
      rd(A_COUNT, q);
      check("t3_count0", q, 8'h00);
      for (int i = 0; i < 4; i++) begin
         rd(A_COUNT, q);
         check($sformatf("t3_seq%0d", i), q, exp_seq[i]);
      end
      rd(A_STATUS, q);
      check("t3_status", q, 8'h01);
      check("t3_irq", {7'd0, irq}, 8'h01);
      wr(A_CTRL, 8'h00);
      @(posedge clk);
      #1 check("t3_irq_ie_off", {7'd0, irq}, 8'h00);
      rd(A_STATUS, q);
      check("t3_status_kept", q, 8'h01);
      wr(A_STATUS, 8'h03);

      // 4: overflow from 8'hFE after two ticks
      wr(A_CMP, 8'h10);
      wr(A_COUNT, 8'hFE);
      wr(A_CTRL, 8'b011);
      @(posedge clk);
      @(posedge clk);
      #1 check("t4_irq_e2", {7'd0, irq}, 8'h00);
      rd(A_COUNT, q);
      check("t4_count", q, 8'h00);
      check("t4_irq", {7'd0, irq}, 8'h01);
      wr(A_CTRL, 8'b010);
      rd(A_STATUS, q);
      check("t4_status", q, 8'h02);
      check("t4_irq_hold", {7'd0, irq}, 8'h01);
      wr(A_STATUS, 8'h02);
      wr(A_CTRL, 8'h00);

      // 5a: COUNT write in a cycle whose tick would have matched
      wr(A_CMP, 8'h21);
      wr(A_COUNT, 8'h20);
      wr(A_STATUS, 8'h03);
      wr(A_CTRL, 8'h01);
      wr(A_COUNT, 8'h40);
      rd(A_COUNT, q);
      check("t5_count_w", q, 8'h40);
      wr(A_CTRL, 8'h00);
      rd(A_STATUS, q);
      check("t5_no_flag", q, 8'h00);

      // 5b: W1C in the match cycle loses to the hardware set
      wr(A_COUNT, 8'h20);
      wr(A_CTRL, 8'h01);
      wr(A_STATUS, 8'h01);
      wr(A_CTRL, 8'h00);
      rd(A_STATUS, q);
      check("t5_w1c_race", q, 8'h01);
      rd(A_COUNT, q);
      check("t5_count", q, 8'h22);
      wr(A_STATUS, 8'h01);
      rd(A_STATUS, q);
      check("t5_w1c", q, 8'h00);

      // 6: read returns pre-write value on a same-cycle read/write
      wr(A_CMP, 8'h12);
      rdwr(A_CMP, 8'h34, q);
      check("t6_rdwr_old", q, 8'h12);
      rd(A_CMP, q);
      check("t6_rd_new", q, 8'h34);
      wr(A_CTRL, 8'b111);
      repeat (3) @(posedge clk);
      @(negedge clk);
      addr = A_COUNT; wdata = 8'h77; we = 1'b1;
      #2 reset = 1'b1;
      #1 check("t6_async_rdata", rdata, 8'h00);
      check("t6_async_irq", {7'd0, irq}, 8'h00);
      @(posedge clk);
      #1 we = 1'b0;
      @(negedge clk) reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         rd(8'hF0 + 8'(i), q);
         check($sformatf("t6_post_rst%0d", i), q, 8'h00);
      end
      check("t6_irq", {7'd0, irq}, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
